// File: rtl/mem_modexp_if.sv
// Command, memory-read and result handshake bundle for the modular-exponentiation engine.
// The host/bench side uses master; the engine uses slave.
interface mem_modexp_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] exp_e;
    logic [DATA_WIDTH-1:0] mod_n;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr_rd;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_buf_empty;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, base_addr, count, exp_e, mod_n, mem_data_out, mem_buf_empty, out_ready,
        input  mem_rd, mem_addr_rd, out_data, out_valid, busy, done, err
    );

    modport slave (
        input  start, base_addr, count, exp_e, mod_n, mem_data_out, mem_buf_empty, out_ready,
        output mem_rd, mem_addr_rd, out_data, out_valid, busy, done, err
    );
endinterface

// File: rtl/mem_modexp_engine.sv
// Reads a block of words from a memory buffer and emits m^e mod n for each word
// using left-to-right square-and-multiply, one modular step per cycle.
module mem_modexp_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input logic        clk,
    input logic        rst,
    mem_modexp_if.slave bus
);
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int unsigned BIT_WIDTH  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        LOAD    = 3'd3,
        SQR     = 3'd4,
        MUL     = 3'd5,
        OUT     = 3'd6,
        FIN     = 3'd7
    } state_t;

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] base_q, base_n;
    logic [CNT_WIDTH-1:0]  count_q, count_n;
    logic [CNT_WIDTH-1:0]  index_q, index_n, index_inc;
    logic [DATA_WIDTH-1:0] exp_q, exp_n;
    logic [DATA_WIDTH-1:0] modulus_q, modulus_n;
    logic [DATA_WIDTH-1:0] acc_q, acc_n;
    logic [DATA_WIDTH-1:0] m_q, m_n;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_n;
    logic [BIT_WIDTH-1:0]  bit_q, bit_n;
    logic                  err_q, err_n;
    logic                  out_valid_q, busy_q, done_q;
    logic                  mem_rd_c;

    logic [DATA_WIDTH-1:0] divisor;
    logic [PROD_WIDTH-1:0] sqr_prod, mul_prod;
    logic [DATA_WIDTH-1:0] sqr_res, mul_res, load_res, one_res;

    // Modular datapath; a zero modulus never reaches compute states, the guard only avoids divide-by-zero.
    assign divisor   = (modulus_q == '0) ? DATA_WIDTH'(1) : modulus_q;
    assign sqr_prod  = PROD_WIDTH'(acc_q) * PROD_WIDTH'(acc_q);
    assign mul_prod  = PROD_WIDTH'(acc_q) * PROD_WIDTH'(m_q);
    assign sqr_res   = DATA_WIDTH'(sqr_prod % PROD_WIDTH'(divisor));
    assign mul_res   = DATA_WIDTH'(mul_prod % PROD_WIDTH'(divisor));
    assign load_res  = bus.mem_data_out % divisor;
    assign one_res   = DATA_WIDTH'(1) % divisor;
    assign index_inc = index_q + CNT_WIDTH'(1);

    // Next-state and next-datapath logic.
    always_comb begin
        state_n    = state_q;
        base_n     = base_q;
        count_n    = count_q;
        index_n    = index_q;
        exp_n      = exp_q;
        modulus_n  = modulus_q;
        acc_n      = acc_q;
        m_n        = m_q;
        bit_n      = bit_q;
        err_n      = err_q;
        mem_rd_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_n    = bus.base_addr;
                    count_n   = bus.count;
                    exp_n     = bus.exp_e;
                    modulus_n = bus.mod_n;
                    index_n   = '0;
                    err_n     = (bus.mod_n < DATA_WIDTH'(2));
                    if ((bus.mod_n < DATA_WIDTH'(2)) || (bus.count == '0)) begin
                        state_n = FIN;
                    end else begin
                        state_n = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (!bus.mem_buf_empty) begin
                    mem_rd_c = 1'b1;
                    state_n  = RD_WAIT;
                end
            end
            RD_WAIT: state_n = LOAD;
            LOAD: begin
                m_n     = load_res;
                acc_n   = one_res;
                bit_n   = BIT_WIDTH'(DATA_WIDTH - 1);
                state_n = SQR;
            end
            SQR: begin
                acc_n = sqr_res;
                if (exp_q[bit_q]) begin
                    state_n = MUL;
                end else if (bit_q == '0) begin
                    state_n = OUT;
                end else begin
                    bit_n   = bit_q - BIT_WIDTH'(1);
                    state_n = SQR;
                end
            end
            MUL: begin
                acc_n = mul_res;
                if (bit_q == '0) begin
                    state_n = OUT;
                end else begin
                    bit_n   = bit_q - BIT_WIDTH'(1);
                    state_n = SQR;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    index_n = index_inc;
                    state_n = (index_inc < count_q) ? RD_REQ : FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Result register captures the accumulator only on entry to OUT so it stays stable while stalled.
        out_data_n = ((state_n == OUT) && (state_q != OUT)) ? acc_n : out_data_q;
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            index_q     <= '0;
            exp_q       <= '0;
            modulus_q   <= '0;
            acc_q       <= '0;
            m_q         <= '0;
            bit_q       <= '0;
            err_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            base_q      <= base_n;
            count_q     <= count_n;
            index_q     <= index_n;
            exp_q       <= exp_n;
            modulus_q   <= modulus_n;
            acc_q       <= acc_n;
            m_q         <= m_n;
            bit_q       <= bit_n;
            err_q       <= err_n;
            out_data_q  <= out_data_n;
            out_valid_q <= (state_n == OUT);
            busy_q      <= (state_n != IDLE);
            done_q      <= (state_n == FIN);
        end
    end

    // Read strobe must react to the empty flag in the same cycle, so it is decoded from state.
    assign bus.mem_rd      = mem_rd_c;
    assign bus.mem_addr_rd = base_q + ADDR_WIDTH'(index_q);
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule
